// File: rtl/mips_regfile_pkg.sv
// rtl/mips_regfile_pkg.sv - shared MIPS register file types and sizes
package MIPS_pkg;

  localparam int MIPS_NUM_REGISTERS  = 32;
  localparam int MIPS_DATA_WIDTH     = 32;
  localparam int MIPS_REG_ADDR_WIDTH = $clog2(MIPS_NUM_REGISTERS);

  typedef logic [MIPS_REG_ADDR_WIDTH-1:0] mips_reg_addr_t;
  typedef logic [MIPS_DATA_WIDTH-1:0]     mips_data_t;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } mips_rf_state_t;

endpackage

// File: rtl/mips_regfile_if.sv
// rtl/mips_regfile_if.sv - operand read / write-back port bundle of the register file
interface mips_regfile_if
  import MIPS_pkg::*;
#(
  parameter int NUM_REGS   = MIPS_NUM_REGISTERS,
  parameter int DATA_WIDTH = MIPS_DATA_WIDTH
);
  localparam int AW = $clog2(NUM_REGS);

  logic                  rd_en;
  logic [AW-1:0]         rs_addr;
  logic [AW-1:0]         rt_addr;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic                  we;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  init_busy;

  modport master (
    output rd_en, rs_addr, rt_addr, we, wr_addr, wr_data,
    input  rs_data, rt_data, init_busy
  );

  modport slave (
    input  rd_en, rs_addr, rt_addr, we, wr_addr, wr_data,
    output rs_data, rt_data, init_busy
  );

endinterface

// File: rtl/mips_regfile_clear_seq.sv
// rtl/mips_regfile_clear_seq.sv - post-reset zero-fill sequencer for the register array
module mips_regfile_clear_seq
  import MIPS_pkg::*;
#(
  parameter int NUM_REGS = MIPS_NUM_REGISTERS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        clr_we,
  output logic [$clog2(NUM_REGS)-1:0] clr_addr,
  output logic                        init_busy
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

  mips_rf_state_t state;
  logic [AW-1:0]  clr_ptr;

  // Register 0 is never stored, so the sweep starts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_ptr <= AW'(1);
    end else if (state == RF_CLEAR) begin
      if (clr_ptr == LAST_ADDR) begin
        state <= RF_READY;
      end else begin
        clr_ptr <= clr_ptr + AW'(1);
      end
    end
  end

  assign clr_we    = (state == RF_CLEAR);
  assign clr_addr  = clr_ptr;
  assign init_busy = (state == RF_CLEAR);

endmodule

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - MIPS register file with registered A/B operand ports and zero-fill on reset
module mips_regfile
  import MIPS_pkg::*;
#(
  parameter int NUM_REGS   = MIPS_NUM_REGISTERS,
  parameter int DATA_WIDTH = MIPS_DATA_WIDTH,
  parameter int BYPASS     = 1
) (
  input logic           clk,
  input logic           rst_n,
  mips_regfile_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  logic                  clr_we;
  logic [AW-1:0]         clr_addr;
  logic                  init_busy;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rs_q;
  logic [DATA_WIDTH-1:0] rt_q;

  mips_regfile_clear_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  // The sequencer owns the write port until the sweep finishes.
  always_comb begin
    mem_we    = clr_we;
    mem_waddr = clr_addr;
    mem_wdata = '0;
    if (!init_busy) begin
      mem_we    = bus.we && (bus.wr_addr != '0);
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [AW-1:0] addr);
    if (addr == '0) begin
      return '0;
    end else if ((BYPASS != 0) && bus.we && (bus.wr_addr == addr)) begin
      return bus.wr_data;
    end else begin
      return mem[addr];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q <= '0;
      rt_q <= '0;
    end else if (!init_busy && bus.rd_en) begin
      rs_q <= read_port(bus.rs_addr);
      rt_q <= read_port(bus.rt_addr);
    end
  end

  assign bus.rs_data   = rs_q;
  assign bus.rt_data   = rt_q;
  assign bus.init_busy = init_busy;

endmodule
